// File: rtl/eq_cfg_pkg.sv
// Shared definitions for the equalizer configuration controller.
package eq_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    SEND      = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [7:0] CTRL_ADDR = 8'h10;
  localparam logic [7:0] STAT_ADDR = 8'h11;
  localparam logic [7:0] VOL_ADDR  = 8'h12;

  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_MUTE   = 1;

  localparam int STAT_BUSY = 0;
  localparam int STAT_PEND = 1;
  localparam int STAT_BAD  = 2;

  localparam logic [7:0] MAX_GAIN_DEF = 8'hC0;
  localparam int         BAND_W       = 4;

  // Saturate a gain/volume code to the allowed ceiling.
  function automatic logic [7:0] clamp_code(input logic [7:0] code, input logic [7:0] limit);
    return (code > limit) ? limit : code;
  endfunction

endpackage

// File: rtl/eq_cfg_regfile.sv
// Shadow/active register storage, write clamp, and registered read-back mux.
module eq_cfg_regfile
  import eq_cfg_pkg::*;
#(
  parameter int         N_BANDS  = 8,
  parameter logic [7:0] MAX_GAIN = MAX_GAIN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        reg_addr,
  input  logic [7:0]        reg_data,
  input  logic              reg_we,
  input  logic              snap,
  input  logic              apply,
  input  logic              busy,
  input  logic              pending,
  input  logic [BAND_W-1:0] band_idx,
  output logic              commit,
  output logic [7:0]        band_gain,
  output logic [7:0]        vol_out,
  output logic              mute,
  output logic [7:0]        rd_data
);

  logic [7:0] gain_sh  [N_BANDS];
  logic [7:0] gain_nxt [N_BANDS];
  logic [7:0] gain_act [N_BANDS];
  logic [7:0] vol_sh, vol_nxt, vol_act;
  logic       mute_sh, mute_nxt, mute_act;
  logic       bad_addr;
  logic [7:0] wr_val, rd_mux;
  logic       hit_band, hit_vol, hit_ctrl, hit_stat;

  // Address decode and next shadow values; the snapshot reads the next
  // values so a commit write carrying the mute bit lands in the same snapshot.
  always_comb begin
    wr_val   = clamp_code(reg_data, MAX_GAIN);
    hit_band = reg_addr < 8'(N_BANDS);
    hit_vol  = reg_addr == VOL_ADDR;
    hit_ctrl = reg_addr == CTRL_ADDR;
    hit_stat = reg_addr == STAT_ADDR;
    commit   = reg_we && hit_ctrl && reg_data[CTRL_COMMIT];
    vol_nxt  = (reg_we && hit_vol) ? wr_val : vol_sh;
    mute_nxt = (reg_we && hit_ctrl) ? reg_data[CTRL_MUTE] : mute_sh;
    for (int i = 0; i < N_BANDS; i++) begin
      gain_nxt[i] = (reg_we && reg_addr == 8'(i)) ? wr_val : gain_sh[i];
    end
  end

  // Select the active gain for the band currently being delivered.
  always_comb begin
    band_gain = '0;
    for (int i = 0; i < N_BANDS; i++) begin
      if (band_idx == BAND_W'(i)) band_gain = gain_act[i];
    end
  end

  // Read-back mux; unmapped addresses return zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_BANDS; i++) begin
      if (reg_addr == 8'(i)) rd_mux = gain_sh[i];
    end
    if (hit_vol) rd_mux = vol_sh;
    if (hit_ctrl) rd_mux[CTRL_MUTE] = mute_sh;
    if (hit_stat) begin
      rd_mux[STAT_BUSY] = busy;
      rd_mux[STAT_PEND] = pending;
      rd_mux[STAT_BAD]  = bad_addr;
    end
  end

  // Shadow registers, sticky bad-address flag and read-back register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BANDS; i++) gain_sh[i] <= '0;
      vol_sh   <= '0;
      mute_sh  <= 1'b0;
      bad_addr <= 1'b0;
      rd_data  <= '0;
    end else begin
      for (int i = 0; i < N_BANDS; i++) gain_sh[i] <= gain_nxt[i];
      vol_sh  <= vol_nxt;
      mute_sh <= mute_nxt;
      rd_data <= rd_mux;
      if (reg_we) begin
        if (hit_stat) bad_addr <= 1'b0;
        else if (!(hit_band || hit_vol || hit_ctrl)) bad_addr <= 1'b1;
      end
    end
  end

  // Active snapshot, loaded at commit; volume/mute go live only on apply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BANDS; i++) gain_act[i] <= '0;
      vol_act  <= '0;
      mute_act <= 1'b0;
      vol_out  <= '0;
      mute     <= 1'b0;
    end else begin
      if (snap) begin
        for (int i = 0; i < N_BANDS; i++) gain_act[i] <= gain_nxt[i];
        vol_act  <= vol_nxt;
        mute_act <= mute_nxt;
      end
      if (apply) begin
        vol_out <= vol_act;
        mute    <= mute_act;
      end
    end
  end

endmodule

// File: rtl/eq_cfg_ctrl.sv
// Commit sequencer: snapshots host settings and streams band gains to the
// filter bank, one band per accepted handshake, starting on a sample tick.
//
// state     | meaning
// IDLE      | no update in flight
// WAIT_TICK | snapshot taken, waiting for sample_tick to go live
// SEND      | presenting band idx on cfg_valid/cfg_ready
// DONE      | last band accepted, cfg_done pulse
module eq_cfg_ctrl
  import eq_cfg_pkg::*;
#(
  parameter int         N_BANDS  = 8,
  parameter logic [7:0] MAX_GAIN = MAX_GAIN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        reg_addr,
  input  logic [7:0]        reg_data,
  input  logic              reg_we,
  input  logic              sample_tick,
  output logic [7:0]        rd_data,
  output logic              cfg_valid,
  output logic [BAND_W-1:0] cfg_band,
  output logic [7:0]        cfg_gain,
  input  logic              cfg_ready,
  output logic              cfg_done,
  output logic [7:0]        vol_out,
  output logic              mute,
  output logic              busy
);

  state_t            state, state_nxt;
  logic [BAND_W-1:0] idx;
  logic              pending, commit, snap, apply, last_band;
  logic [7:0]        gain_sel;

  assign last_band = idx == BAND_W'(N_BANDS - 1);
  assign cfg_valid = state == SEND;
  assign cfg_band  = cfg_valid ? idx : '0;
  assign cfg_gain  = cfg_valid ? gain_sel : '0;
  assign cfg_done  = state == DONE;
  assign busy      = state != IDLE;

  eq_cfg_regfile #(
    .N_BANDS  (N_BANDS),
    .MAX_GAIN (MAX_GAIN)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_addr  (reg_addr),
    .reg_data  (reg_data),
    .reg_we    (reg_we),
    .snap      (snap),
    .apply     (apply),
    .busy      (busy),
    .pending   (pending),
    .band_idx  (idx),
    .commit    (commit),
    .band_gain (gain_sel),
    .vol_out   (vol_out),
    .mute      (mute),
    .rd_data   (rd_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic with snapshot/apply strobes.
  always_comb begin
    state_nxt = state;
    snap      = 1'b0;
    apply     = 1'b0;
    case (state)
      IDLE: begin
        if (commit) begin
          state_nxt = WAIT_TICK;
          snap      = 1'b1;
        end
      end
      WAIT_TICK: begin
        if (sample_tick) begin
          state_nxt = SEND;
          apply     = 1'b1;
        end
      end
      SEND: begin
        if (cfg_ready && last_band) state_nxt = DONE;
      end
      DONE: begin
        // A commit landing in this very cycle is folded in like a pending one.
        if (pending || commit) begin
          state_nxt = WAIT_TICK;
          snap      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Band index and collapsed pending-commit flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      pending <= 1'b0;
    end else begin
      if (state == SEND) begin
        if (cfg_ready) idx <= last_band ? '0 : idx + BAND_W'(1);
      end else begin
        idx <= '0;
      end
      if (state == DONE)                  pending <= 1'b0;
      else if (commit && state != IDLE)   pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eq_cfg_ctrl.sv
// Self-checking bench for eq_cfg_ctrl against a register/transaction model.
module tb_eq_cfg_ctrl;

  localparam int         NB     = 8;
  localparam logic [7:0] A_CTRL = 8'h10;
  localparam logic [7:0] A_STAT = 8'h11;
  localparam logic [7:0] A_VOL  = 8'h12;

  logic       clk, rst_n;
  logic [7:0] reg_addr, reg_data;
  logic       reg_we, sample_tick, cfg_ready;
  logic [7:0] rd_data, cfg_gain, vol_out;
  logic [3:0] cfg_band;
  logic       cfg_valid, cfg_done, mute, busy;

  eq_cfg_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .reg_we      (reg_we),
    .sample_tick (sample_tick),
    .rd_data     (rd_data),
    .cfg_valid   (cfg_valid),
    .cfg_band    (cfg_band),
    .cfg_gain    (cfg_gain),
    .cfg_ready   (cfg_ready),
    .cfg_done    (cfg_done),
    .vol_out     (vol_out),
    .mute        (mute),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: host shadows, the snapshot in flight, and what is live.
  logic [7:0] sh [NB];
  logic [7:0] snap_m [NB];
  logic [7:0] vol_m, snap_vol, act_vol;
  logic       mute_m, snap_mute, act_mute, bad_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] clampm(input int d);
    return (d > 192) ? 8'd192 : 8'(d);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) sh[i] = 8'h00;
    vol_m = 0; mute_m = 0; bad_m = 0; act_vol = 0; act_mute = 0;
  endfunction

  function automatic void model_wr(input logic [7:0] a, input logic [7:0] d);
    if (int'(a) < NB)  sh[int'(a)] = clampm(int'(d));
    else if (a == A_VOL)  vol_m = clampm(int'(d));
    else if (a == A_CTRL) mute_m = d[1];
    else if (a == A_STAT) bad_m = 1'b0;
    else                  bad_m = 1'b1;
  endfunction

  function automatic logic [7:0] rd_model(input logic [7:0] a, input logic b, input logic p);
    if (int'(a) < NB)  return sh[int'(a)];
    if (a == A_VOL)  return vol_m;
    if (a == A_CTRL) return {6'b0, mute_m, 1'b0};
    if (a == A_STAT) return {5'b0, bad_m, p, b};
    return 8'h00;
  endfunction

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic with_tick = 1'b0);
    @(negedge clk);
    reg_addr = a; reg_data = d; reg_we = 1'b1; sample_tick = with_tick;
    @(negedge clk);
    reg_we = 1'b0; sample_tick = 1'b0;
    model_wr(a, d);
  endtask

  task automatic rd(input logic [7:0] a, input string tag);
    logic [7:0] exp;
    exp = rd_model(a, 1'b0, 1'b0);
    @(negedge clk);
    reg_addr = a;
    @(negedge clk);
    chk(tag, rd_data, exp);
  endtask

  task automatic commit(input logic m, input logic with_tick);
    wr(A_CTRL, {6'b0, m, 1'b1}, with_tick);
    snap_m = sh; snap_vol = vol_m; snap_mute = mute_m;
  endtask

  // mode 0: ready high, 1: random ready, 2: 5-cycle stall on band 3,
  // 3: stall on band 2 while the host edits band 2 and commits twice.
  task automatic run_seq(input int mode, input int pre_idle, input logic busy_after, input string tag);
    int idx = 0, stall = 0, step = 0, budget = 0;
    repeat (pre_idle) begin
      cfg_ready = 1'($urandom % 2);
      @(negedge clk);
    end
    chk({tag, "_pre_valid"}, cfg_valid, 0);
    chk({tag, "_pre_vol"}, vol_out, act_vol);
    chk({tag, "_pre_mute"}, mute, act_mute);
    chk({tag, "_pre_busy"}, busy, 1);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    act_vol = snap_vol; act_mute = snap_mute;
    chk({tag, "_vol"}, vol_out, act_vol);
    chk({tag, "_mute"}, mute, act_mute);
    while (idx < NB && budget < 400) begin
      budget++;
      chk({tag, "_valid"}, cfg_valid, 1);
      chk({tag, "_band"}, cfg_band, idx);
      chk({tag, "_gain"}, cfg_gain, snap_m[idx]);
      cfg_ready = 1'b1;
      case (mode)
        1: cfg_ready = 1'($urandom % 2);
        2: if (idx == 3 && stall < 5) begin cfg_ready = 1'b0; stall++; end
        3: if (idx == 2 && step < 5) begin
             cfg_ready = 1'b0;
             case (step)
               0: begin reg_addr = 8'd2; reg_data = 8'h55; reg_we = 1'b1; model_wr(8'd2, 8'h55); end
               1, 2: begin reg_addr = A_CTRL; reg_data = 8'h01; reg_we = 1'b1; model_wr(A_CTRL, 8'h01); end
               3: begin reg_we = 1'b0; reg_addr = A_STAT; end
               default: chk({tag, "_stat_pending"}, rd_data, 8'h03);
             endcase
             step++;
           end
        default: ;
      endcase
      @(negedge clk);
      reg_we = 1'b0;
      if (cfg_ready) idx++;
    end
    if (budget >= 400) chk({tag, "_timeout"}, 0, 1);
    cfg_ready = 1'b0;
    chk({tag, "_done"}, cfg_done, 1);
    chk({tag, "_done_valid"}, cfg_valid, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, cfg_done, 0);
    chk({tag, "_busy_after"}, busy, busy_after);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; reg_addr = 0; reg_data = 0; reg_we = 0; sample_tick = 0; cfg_ready = 0;
    model_reset();
    for (int i = 0; i < NB; i++) snap_m[i] = 0;
    snap_vol = 0; snap_mute = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", cfg_valid, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vol", vol_out, 0);
    chk("rst_mute", mute, 0);
    chk("rst_band", cfg_band, 0);
    chk("rst_gain", cfg_gain, 0);
    chk("rst_rd", rd_data, 0);
    rst_n = 1'b1;
    rd(8'd0, "rst_rd0");
    rd(A_STAT, "rst_rdstat");

    // Clamp and commit
    wr(8'd0, 8'h20);
    wr(8'd1, 8'hFF);
    rd(8'd1, "clamp_rd1");
    chk("clamp_model", sh[1], 8'hC0);
    commit(1'b0, 1'b0);
    run_seq(0, 2, 1'b0, "basic");

    // Backpressure on band 3
    for (int i = 0; i < NB; i++) wr(8'(i), 8'($urandom));
    commit(1'b0, 1'b0);
    run_seq(2, 1, 1'b0, "bp");

    // Commit while busy: old band 2 first, then exactly one more sequence
    commit(1'b0, 1'b0);
    run_seq(3, 0, 1'b1, "pend1");
    snap_m = sh; snap_vol = vol_m; snap_mute = mute_m;
    chk("pend_new_b2", snap_m[2], 8'h55);
    run_seq(0, 2, 1'b0, "pend2");
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    chk("pend_no_third", cfg_valid, 0);
    chk("pend_idle", busy, 0);

    // Bad address, volume and mute
    wr(8'h30, 8'hAA);
    rd(A_STAT, "bad_set");
    wr(A_STAT, 8'h00);
    rd(A_STAT, "bad_clr");
    wr(A_VOL, 8'h40);
    commit(1'b1, 1'b0);
    run_seq(0, 3, 1'b0, "volmute");

    // Randomized rounds
    for (int it = 0; it < 6; it++) begin
      repeat (4) begin
        int r;
        r = int'($urandom % 10);
        if (r < 7)       wr(8'($urandom % NB), 8'($urandom));
        else if (r == 7) wr(A_VOL, 8'($urandom));
        else if (r == 8) wr(8'h40 + 8'($urandom % 64), 8'($urandom));
        else             wr(A_STAT, 8'($urandom));
      end
      repeat (2) begin
        int r;
        logic [7:0] a;
        r = int'($urandom % 4);
        a = (r == 0) ? A_VOL : (r == 1) ? A_CTRL : (r == 2) ? A_STAT : 8'($urandom % NB);
        rd(a, "rnd_rd");
      end
      commit(1'($urandom % 2), it == 0);
      run_seq(int'($urandom % 3), int'($urandom % 3), 1'b0, "rnd");
    end

    // Reset in the middle of SEND
    wr(8'd4, 8'h33);
    commit(1'b1, 1'b0);
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0; cfg_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_band4", cfg_band, 4);
    cfg_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_valid", cfg_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", cfg_done, 0);
    chk("mid_vol", vol_out, 0);
    model_reset();
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_done", cfg_done, 0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mid_post_busy", busy, 0);
      chk("mid_post_done", cfg_done, 0);
    end
    rd(8'd4, "mid_rd4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/eq_cfg_ctrl.md
Name: eq_cfg_ctrl

Overview:
Configuration controller between the I2C slave register-write port and the equalizer filter bank.
- Holds host-writable shadow registers: per-band gains, master volume, control.
- On a commit request, snapshots the shadow registers and delivers each band gain to the filter bank over a valid/ready handshake, aligned to the audio sample tick.
- Provides read-back data to the I2C slave's data_in.

Parameters:
N_BANDS, 8, number of equalizer bands (1..16)
MAX_GAIN, 8'hC0, upper clamp for band gain and master volume codes
CTRL_ADDR, 8'h10, address of the control register
STAT_ADDR, 8'h11, address of the read-only status register
VOL_ADDR, 8'h12, address of the master volume register

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
reg_addr  in  8  register address from I2C slave
reg_data  in  8  register write data from I2C slave
reg_we  in  1  one-cycle write strobe from I2C slave
sample_tick  in  1  one-cycle pulse per audio sample
rd_data  out  8  read-back data for the I2C slave data_in
cfg_valid  out  1  band update valid
cfg_band  out  4  band index of the current update
cfg_gain  out  8  gain code of the current update
cfg_ready  in  1  filter bank accepts the update
cfg_done  out  1  one-cycle pulse after the last band is accepted
vol_out  out  8  active master volume
mute  out  1  active mute
busy  out  1  commit sequence in progress

Behaviour:
Reset values:
- All outputs 0.
- All shadow and active registers 0, including vol_out.
- FSM in IDLE.

Register map:
- Addresses 0..N_BANDS-1: band gain shadow.
- VOL_ADDR: volume shadow.
- CTRL_ADDR bit0 = commit (self-clearing, reads 0), bit1 = mute shadow.
- STAT_ADDR: bit0 busy, bit1 pending, bit2 bad_addr (sticky). Read-only; a write to STAT_ADDR clears bad_addr.
- Writes to any other address are ignored and set bad_addr.

Write and read rules:
- Band and volume writes with data > MAX_GAIN store MAX_GAIN.
- Shadow registers update on the cycle after reg_we.
- rd_data is registered: one-cycle latency from a reg_addr change. Unmapped addresses read 8'h00.

FSM states: IDLE, WAIT_TICK, SEND, DONE.
- IDLE -> WAIT_TICK on a commit write. On that cycle the band shadows, volume and mute are snapshotted into the active set.
- WAIT_TICK -> SEND on sample_tick. vol_out and mute take the snapshot values in that same cycle.
- SEND:
  - cfg_valid=1, cfg_band=idx, cfg_gain=active[idx].
  - cfg_band, cfg_gain and cfg_valid are held stable until cfg_ready.
  - On valid&ready: if idx==N_BANDS-1 go DONE, else idx+1 with cfg_valid staying high.
- DONE: cfg_done=1 for one cycle, cfg_valid=0, then IDLE. If pending is set, go to WAIT_TICK instead, re-snapshot from the shadows and clear pending.

Handshake and status details:
- busy is 1 in every state except IDLE.
- A commit while busy sets pending; shadow writes during busy are accepted but never alter the in-flight snapshot.
- Multiple commits while busy collapse into one pending commit.
- sample_tick and commit in the same cycle in IDLE: snapshot is taken; the transition to SEND waits for the next tick.
- cfg_ready asserted while cfg_valid=0 is ignored.
- A reset mid-sequence immediately returns to IDLE with all outputs 0. No partial cfg_done is issued.

Decomposition:
- Shared package eq_cfg_pkg holds:
  - FSM state encoding (2 bits)
  - register addresses CTRL_ADDR, STAT_ADDR, VOL_ADDR
  - status bit positions
  - MAX_GAIN default
  - band index width (4)
- One sub-module is natural: eq_cfg_regfile, containing the shadow/active arrays, the clamp and the read mux. The FSM and handshake stay in the top.

Test Plan:
1. Reset check: assert rst_n=0 for 3 cycles -> all outputs 0, rd_data reads 8'h00 at addr 0 and STAT_ADDR.
2. Clamp and commit: write band0=8'h20, band1=8'hFF, then CTRL=8'h01.
   - Read addr 1 -> 8'hC0.
   - At the next sample_tick, cfg_valid rises with band 0 / gain 8'h20.
   - With cfg_ready tied high, bands 0..7 are delivered on consecutive cycles and cfg_band=1 carries 8'hC0.
   - cfg_done pulses once and busy drops the next cycle.
3. Backpressure: hold cfg_ready=0 for 5 cycles during band 3 -> cfg_band=3 and cfg_gain stay constant, and idx does not advance.
4. Commit while busy: during SEND write band2=8'h55, then commit twice.
   - STAT reads pending=1.
   - The first sequence delivers the old band2 value.
   - Exactly one further sequence follows, delivering 8'h55.
5. Bad address and volume/mute: write addr 8'h30.
   - STAT bit2 reads 1, and a write to STAT_ADDR clears it.
   - Then write VOL=8'h40 and CTRL=8'h03: vol_out=8'h40 and mute=1 appear exactly on the next sample_tick, not before.
6. Reset mid-operation: deassert rst_n while in SEND at band 4 -> cfg_valid drops immediately, no cfg_done, and busy=0 after release.
